// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: frame FSM states and the
// line-source codes reported on mux_sel.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] MUX_IDLE  = 2'b00;
  localparam logic [1:0] MUX_START = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// ser_data is the bit the frame FSM registers onto the line at the coming edge.
module uart_tx_serializer #(
  parameter int Data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [Data_width-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CounterWidth = (Data_width > 1) ? $clog2(Data_width) : 1;

  logic [Data_width-1:0]   shift_reg;
  logic [CounterWidth-1:0] bit_count;

  // bit_count is the index of the data bit currently on the line
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_count <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_count <= '0;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[Data_width-1:1]};
      bit_count <= bit_count + CounterWidth'(1);
    end
  end

  // When shifting, the next line bit is the one about to move into position 0
  assign ser_data = shift_en ? shift_reg[1] : shift_reg[0];
  assign ser_done = (bit_count == CounterWidth'(Data_width - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame controller: start/data/parity/stop sequencing with
// registered TX_OUT/Busy/mux_sel. Optional macro UART_TX_BACK2BACK_EN.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int Data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic [1:0]            mux_sel
);

  tx_state_t state;
  logic      par_en_q;
  logic      accept;
  logic      shift_en;
  logic      ser_data;
  logic      ser_done;

`ifdef UART_TX_BACK2BACK_EN
  // A request seen in the stop bit chains the next frame with no idle gap
  assign accept = Data_Valid && ((state == IDLE) || (state == STOP));
`else
  assign accept = Data_Valid && (state == IDLE);
`endif

  assign shift_en = (state == DATA) && !ser_done;

  uart_tx_serializer #(
    .Data_width(Data_width)
  ) u_serializer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift_en (shift_en),
    .load_data(P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      mux_sel  <= MUX_IDLE;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            mux_sel  <= MUX_START;
            par_en_q <= PAR_EN;
          end
        end
        START: begin
          state   <= DATA;
          TX_OUT  <= ser_data;
          mux_sel <= MUX_DATA;
        end
        DATA: begin
          if (!ser_done) begin
            TX_OUT <= ser_data;
          end else if (par_en_q) begin
            state   <= PARITY;
            TX_OUT  <= par_bit;
            mux_sel <= MUX_PAR;
          end else begin
            state   <= STOP;
            TX_OUT  <= 1'b1;
            mux_sel <= MUX_IDLE;
          end
        end
        PARITY: begin
          state   <= STOP;
          TX_OUT  <= 1'b1;
          mux_sel <= MUX_IDLE;
        end
        STOP: begin
          if (accept) begin
            state    <= START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
            mux_sel  <= MUX_START;
            par_en_q <= PAR_EN;
          end else begin
            state   <= IDLE;
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
            mux_sel <= MUX_IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          mux_sel <= MUX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame; the back-to-back step
// follows UART_TX_BACK2BACK_EN when the macro is defined for the build.
module tb_uart_tx_frame;
  import uart_tx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       par_bit = 1'b0;
  logic       TX_OUT;
  logic       Busy;
  logic [1:0] mux_sel;

  int errors = 0;
  int checks = 0;

  uart_tx_frame #(
    .Data_width(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .par_bit   (par_bit),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy),
    .mux_sel   (mux_sel)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic tx_e, input logic busy_e,
                              input logic [1:0] mux_e);
    checks++;
    assert ({TX_OUT, Busy, mux_sel} === {tx_e, busy_e, mux_e})
    else begin
      errors++;
      $error("[TB] FAIL %s: observed tx=%b busy=%b mux=%b, expected tx=%b busy=%b mux=%b",
             tag, TX_OUT, Busy, mux_sel, tx_e, busy_e, mux_e);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input string tag);
    P_DATA     = d;
    PAR_EN     = pe;
    Data_Valid = 1'b1;
    tick();
    check_output({tag, "_start"}, 1'b0, 1'b1, MUX_START);
  endtask

  // hold=1 keeps Data_Valid high and scrambles P_DATA/PAR_EN every cycle
  task automatic frame_body(input logic [7:0] d, input logic pe, input logic pb,
                            input logic hold, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (hold) begin
        P_DATA = 8'($urandom);
        PAR_EN = ~PAR_EN;
      end else begin
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
      end
      tick();
      check_output($sformatf("%s_d%0d", tag, i), d[i], 1'b1, MUX_DATA);
    end
    if (pe) begin
      tick();
      check_output({tag, "_parity"}, pb, 1'b1, MUX_PAR);
    end
    tick();
    check_output({tag, "_stop"}, 1'b1, 1'b1, MUX_IDLE);
  endtask

  initial begin
    tick();
    tick();
    check_output("reset", 1'b1, 1'b0, MUX_IDLE);
    #2 RST = 1'b1;
    tick();
    check_output("idle_after_reset", 1'b1, 1'b0, MUX_IDLE);

    // 8'hA5 with parity bit 0: 0,1,0,1,0,0,1,0,1,0,1
    par_bit = 1'b0;
    start_frame(8'hA5, 1'b1, "a5");
    frame_body(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
    tick();
    check_output("a5_idle", 1'b1, 1'b0, MUX_IDLE);

    // 8'h3C without parity: 0,0,0,1,1,1,1,0,0,1
    start_frame(8'h3C, 1'b0, "3c");
    frame_body(8'h3C, 1'b0, 1'b0, 1'b0, "3c");
    tick();
    check_output("3c_idle", 1'b1, 1'b0, MUX_IDLE);

    // Data_Valid held high: only the accepted byte goes out
    start_frame(8'h5A, 1'b0, "hold");
    frame_body(8'h5A, 1'b0, 1'b0, 1'b1, "hold");
    P_DATA  = 8'hC3;
    PAR_EN  = 1'b1;
    par_bit = 1'b1;
`ifdef UART_TX_BACK2BACK_EN
    tick();
    check_output("b2b_start", 1'b0, 1'b1, MUX_START);
`else
    tick();
    check_output("gap_idle", 1'b1, 1'b0, MUX_IDLE);
    tick();
    check_output("c3_start", 1'b0, 1'b1, MUX_START);
`endif
    frame_body(8'hC3, 1'b1, 1'b1, 1'b0, "c3");
    tick();
    check_output("c3_idle", 1'b1, 1'b0, MUX_IDLE);

    // Reset asserted mid-DATA aborts at once
    par_bit = 1'b0;
    start_frame(8'hFF, 1'b1, "rst");
    Data_Valid = 1'b0;
    tick();
    tick();
    tick();
    check_output("rst_mid", 1'b1, 1'b1, MUX_DATA);
    #2 RST = 1'b0;
    #1 check_output("rst_abort", 1'b1, 1'b0, MUX_IDLE);
    tick();
    check_output("rst_hold", 1'b1, 1'b0, MUX_IDLE);
    #2 RST = 1'b1;
    tick();
    check_output("rst_release", 1'b1, 1'b0, MUX_IDLE);

    par_bit = 1'b1;
    start_frame(8'h96, 1'b1, "post");
    frame_body(8'h96, 1'b1, 1'b1, 1'b0, "post");
    tick();
    check_output("post_idle", 1'b1, 1'b0, MUX_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Frame controller and serializer for the UART transmitter. Accepts a parallel byte from the upstream data source, walks the start/data/parity/stop sequence, and drives the serial line TX_OUT. It consumes the registered parity bit from the TX parity stage, and drives the mux_sel/Busy status that the parity stage and upstream logic use.

## Interface
- Data_width, 8, payload bits per frame (≥2)
- CLK  in  1  bit-rate clock; one TX bit per cycle
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  Data_width  parallel payload; sampled only on acceptance
- Data_Valid  in  1  request strobe; accepted only when block is idle (see Configuration)
- PAR_EN  in  1  1 = insert parity bit; sampled on acceptance
- par_bit  in  1  parity bit from parity stage; must be stable from first DATA cycle to end of PARITY cycle
- TX_OUT  out  1  serial line, idle-high, LSB first
- Busy  out  1  high while a frame is on the line
- mux_sel  out  2  current line source: 00 idle/stop (1), 01 start (0), 10 data, 11 parity

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0, mux_sel=00. On Data_Valid=1: latch P_DATA into the shift register, latch PAR_EN, clear bit counter, go to START.
- START: one cycle, TX_OUT=0, mux_sel=01, Busy=1. Next state is DATA.
- DATA: Data_width cycles, TX_OUT=shift_reg[0], mux_sel=10; shift right each cycle; counter increments 0..Data_width-1. At count Data_width-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: one cycle, TX_OUT=par_bit, mux_sel=11. Next state is STOP.
- STOP: one cycle, TX_OUT=1, mux_sel=00, Busy=1. Next state is IDLE, or START under the Configuration feature.
- Bit counter is $clog2(Data_width) bits wide. It never wraps inside a frame and clears on every acceptance.
- Data_Valid during START/DATA/PARITY is ignored; P_DATA changes there have no effect on the frame.
- Reset mid-frame aborts immediately. The block enters IDLE with the reset outputs below; no partial stop bit is sent.

## Timing
- Reset values: TX_OUT=1, Busy=0, mux_sel=00, state IDLE, shift register 0, counter 0.
- TX_OUT, Busy and mux_sel are registered and aligned with the state.
- If Data_Valid is sampled high at edge k, then from edge k+1: TX_OUT=0, Busy=1, mux_sel=01.
- First data bit (P_DATA[0]) appears from edge k+2.
- Frame length is 2+Data_width+PAR_EN cycles: 11 for 8-bit data with parity, 10 without.
- Busy falls at the edge that enters IDLE.
- Without the Configuration feature, at least one IDLE cycle separates frames, so the minimum frame-to-frame period is frame length + 1.

## Configuration
- Macro: UART_TX_BACK2BACK_EN.
- Defined: Data_Valid sampled high in STOP is accepted and the state goes STOP→START directly. P_DATA and PAR_EN are latched as in IDLE, and Busy stays high with no IDLE gap. Frame period equals frame length.
- Undefined: Data_Valid in STOP is ignored; STOP always goes to IDLE.

## Structure
- Shared package uart_tx_pkg holds:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP);
  - mux_sel constants MUX_IDLE=2'b00, MUX_START=2'b01, MUX_DATA=2'b10, MUX_PAR=2'b11.
- Sub-module uart_tx_serializer holds the shift register and bit counter. It exposes load, shift enable, ser_data and ser_done.
- FSM and output registers live in the top.

## Test plan
- Reset: assert RST=0 mid-DATA of a frame → same cycle TX_OUT=1, Busy=0, mux_sel=00; next frame starts cleanly.
- P_DATA=8'hA5, PAR_EN=1, par_bit=0, single Data_Valid pulse → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. Busy high for exactly 11 cycles; mux_sel 01,10×8,11,00.
- P_DATA=8'h3C, PAR_EN=0 → 10-cycle frame 0,0,0,1,1,1,1,0,0,1; mux_sel never 11.
- Data_Valid held high throughout with P_DATA changing every cycle → only the value at the accepting edge is sent. Without the macro, one IDLE cycle occurs between frames.
- With UART_TX_BACK2BACK_EN, a Data_Valid pulse in the STOP cycle → next cycle TX_OUT=0, mux_sel=01, Busy never drops.
- PAR_EN toggled mid-frame → frame format follows the value latched at acceptance.
